multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the non-pipelined RV32 core; replaces single-cycle control so one ALU and a shared memory port are reused across FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Decodes R (0110011), lw (0000011), sw (0100011) and beq (1100011).
- Drives datapath enables and handshakes instruction and data memory with req/ready.

---
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the non-pipelined RV32 core (R, lw, sw, beq).
// Define MCTRL_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired is 0.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [1:0]       immsel,
    output logic [1:0]       aluop,
    output logic             alusrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             regwrite_en,
    output logic             Branch,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      op_q, op_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            retire;

    always_ff @(posedge clk) begin
        state_q <= state_d;
        op_q    <= op_d;
        tmo_q   <= tmo_d;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tmo_d       = tmo_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        immsel      = 2'b00;
        aluop       = 2'b00;
        alusrc      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        regwrite_en = 1'b0;
        Branch      = 1'b0;
        illegal_op  = 1'b0;
        bus_err     = 1'b0;
        state       = 3'd0;

        if (rst) begin
            state_d = StFetch;
            op_d    = 7'd0;
            tmo_d   = '0;
        end else begin
            state = state_q;
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = StDecode;
                    end
                end
                StDecode: begin
                    op_d = opcode;
                    if (opcode == OpR || opcode == OpLw || opcode == OpSw || opcode == OpBeq) begin
                        state_d = StExecute;
                    end else begin
                        illegal_op = 1'b1;
                        pc_write   = 1'b1;
                        state_d    = StFetch;
                    end
                end
                StExecute: begin
                    tmo_d = '0;
                    case (op_q)
                        OpR: begin
                            aluop   = 2'b10;
                            state_d = StWriteback;
                        end
                        OpLw: begin
                            alusrc  = 1'b1;
                            state_d = StMem;
                        end
                        OpSw: begin
                            immsel  = 2'b01;
                            alusrc  = 1'b1;
                            state_d = StMem;
                        end
                        OpBeq: begin
                            immsel   = 2'b10;
                            aluop    = 2'b01;
                            Branch   = 1'b1;
                            pc_write = 1'b1;
                            pc_sel   = zero;
                            retire   = 1'b1;
                            state_d  = StFetch;
                        end
                        default: state_d = StFetch;
                    endcase
                end
                StMem: begin
                    alusrc   = 1'b1;
                    immsel   = (op_q == OpSw) ? 2'b01 : 2'b00;
                    MemRead  = (op_q == OpLw);
                    MemWrite = (op_q == OpSw);
                    // A ready arriving in the timeout cycle still completes the access.
                    if (dmem_ready) begin
                        if (op_q == OpSw) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = StFetch;
                        end else begin
                            state_d = StWriteback;
                        end
                    end else if (tmo_q == TmoLast) begin
                        bus_err  = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                StWriteback: begin
                    regwrite_en = 1'b1;
                    MemtoReg    = (op_q == OpLw);
                    pc_write    = 1'b1;
                    retire      = 1'b1;
                    state_d     = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

`ifdef MCTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = rst ? '0 : retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        retired_q <= retired_d;
    end

    assign retired = rst ? '0 : retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign retired       = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios then random stimulus, all checked
// every cycle against a per-instruction path-table model.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 16;
    localparam int unsigned CW = 4;

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpIll = 7'b0010011;

    logic          clk = 1'b0;
    logic          rst, zero, imem_ready, dmem_ready;
    logic [6:0]    opcode;
    logic          imem_req, ir_write, pc_write, pc_sel, alusrc;
    logic [1:0]    immsel, aluop;
    logic          MemRead, MemWrite, MemtoReg, regwrite_en, Branch, illegal_op, bus_err;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
        .immsel(immsel), .aluop(aluop), .alusrc(alusrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .regwrite_en(regwrite_en),
        .Branch(Branch), .illegal_op(illegal_op), .bus_err(bus_err),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, ir_write, pc_write, pc_sel;
        logic [1:0] immsel, aluop;
        logic       alusrc, mem_read, mem_write, mem_to_reg, regwrite_en, branch;
        logic       illegal_op, bus_err;
    } outs_t;

    int checks = 0;
    int errors = 0;

    // Model: instruction class (0 R, 1 lw, 2 sw, 3 beq, 4 illegal), position along its
    // state path, MEM wait count and number of retired instructions.
    int          m_cls = 0;
    int          m_idx = 0;
    int          m_wait = 0;
    int unsigned m_ret = 0;
    int          path [0:4][0:4] = '{'{0, 1, 2, 4, -1}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 3, -1},
                                     '{0, 1, 2, -1, -1}, '{0, 1, -1, -1, -1}};

    outs_t         g;
    int            g_state;
    logic [CW-1:0] g_ret;

    function automatic int classify(input logic [6:0] op);
        case (op)
            OpR:     return 0;
            OpLw:    return 1;
            OpSw:    return 2;
            OpBeq:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [CW-1:0] exp_ret(input int unsigned n);
`ifdef MCTRL_RETIRE_CNT_EN
        return CW'(n);
`else
        return CW'(n & 0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic [6:0] op, input logic z,
                        input logic ir, input logic dr);
        outs_t e;
        int    es, ph;
        bit    adv, done, ret;
        rst = r; opcode = op; zero = z; imem_ready = ir; dmem_ready = dr;
        @(negedge clk);
        g = {imem_req, ir_write, pc_write, pc_sel, immsel, aluop, alusrc, MemRead, MemWrite,
             MemtoReg, regwrite_en, Branch, illegal_op, bus_err};
        g_state = int'(state);
        g_ret   = retired;
        e = '0; es = 0; adv = 0; done = 0; ret = 0;
        if (r) begin
            m_idx = 0; m_wait = 0; m_ret = 0;
        end else begin
            ph = path[m_cls][m_idx];
            es = ph;
            case (ph)
                0: begin
                    e.imem_req = 1'b1;
                    if (ir) begin e.ir_write = 1'b1; adv = 1; end
                end
                1: begin
                    m_cls = classify(op);
                    if (m_cls == 4) begin e.illegal_op = 1'b1; e.pc_write = 1'b1; done = 1; end
                    else adv = 1;
                end
                2: begin
                    case (m_cls)
                        0: begin e.aluop = 2'b10; adv = 1; end
                        1: begin e.alusrc = 1'b1; adv = 1; end
                        2: begin e.immsel = 2'b01; e.alusrc = 1'b1; adv = 1; end
                        default: begin
                            e.immsel = 2'b10; e.aluop = 2'b01; e.branch = 1'b1;
                            e.pc_write = 1'b1; e.pc_sel = z; ret = 1; done = 1;
                        end
                    endcase
                end
                3: begin
                    e.mem_read  = (m_cls == 1);
                    e.mem_write = (m_cls == 2);
                    e.alusrc    = 1'b1;
                    e.immsel    = (m_cls == 2) ? 2'b01 : 2'b00;
                    if (dr) begin
                        if (m_cls == 2) begin e.pc_write = 1'b1; ret = 1; done = 1; end
                        else adv = 1;
                    end else begin
                        m_wait++;
                        if (m_wait == int'(TO)) begin
                            e.bus_err = 1'b1; e.pc_write = 1'b1; done = 1;
                        end
                    end
                end
                default: begin
                    e.regwrite_en = 1'b1; e.mem_to_reg = (m_cls == 1);
                    e.pc_write = 1'b1; ret = 1; done = 1;
                end
            endcase
        end
        chk("outputs", 32'(g), 32'(e));
        chk("state", g_state, es);
        chk("retired", 32'(g_ret), 32'(exp_ret(m_ret)));
        if (ret) m_ret++;
        if (done) begin m_idx = 0; m_wait = 0; end
        else if (adv) m_idx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          rseq [0:3] = '{0, 1, 2, 4};
        int          nmr, nmw, nbe;
        bit          drop;
        logic        zz;
        logic [31:0] tmp;
        logic [6:0]  rop;

        rst = 1'b1; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) begin
            tick(1'b1, 7'd0, 1'b0, 1'b1, 1'b0);
            chk("rst_outs", 32'(g), 32'd0);
            chk("rst_state", g_state, 0);
        end

        for (int i = 0; i < 4; i++) begin
            tick(1'b0, OpR, 1'b0, 1'b1, 1'b1);
            chk("r_state", g_state, rseq[i]);
            if (i == 0) chk("first_fetch", {g.imem_req, g.ir_write}, 2'b11);
            if (i == 2) chk("r_aluop", {g.aluop, g.alusrc}, 3'b100);
            if (i == 3) chk("r_wb", {g.regwrite_en, g.mem_to_reg}, 2'b10);
        end

        for (int k = 0; k < 2; k++) begin
            zz = (k == 0);
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, OpBeq, zz, 1'b1, 1'b1);
                if (i == 0) chk("beq_start_state", g_state, 0);
                if (i == 2) chk("beq_exec", {g.pc_write, g.pc_sel, g.branch}, {1'b1, zz, 1'b1});
            end
        end

        nmr = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, OpLw, 1'b0, 1'b1, i == 6);
            if (i == 0) chk("lw_retired_before", 32'(g_ret), 32'(exp_ret(3)));
            nmr += int'(g.mem_read);
            if (i == 7) chk("lw_wb", {g.regwrite_en, g.mem_to_reg, g_state[2:0]}, 5'b11100);
        end
        chk("lw_memread_cycles", nmr, 4);

        nmw = 0; nbe = 0;
        for (int i = 0; i < 19; i++) begin
            tick(1'b0, OpSw, 1'b0, 1'b1, 1'b0);
            nmw += int'(g.mem_write);
            nbe += int'(g.bus_err);
            if (i == 18) chk("sw_tmo_last", {g.mem_write, g.bus_err, g.pc_write}, 3'b111);
        end
        chk("sw_tmo_memwrite_cycles", nmw, 16);
        chk("sw_tmo_buserr_count", nbe, 1);

        for (int i = 0; i < 2; i++) begin
            tick(1'b0, OpIll, 1'b0, 1'b1, 1'b1);
            if (i == 0) chk("ill_retired_before", 32'(g_ret), 32'(exp_ret(4)));
            if (i == 1) chk("ill_decode", {g.illegal_op, g.pc_write, g.regwrite_en}, 3'b110);
        end

        // Ready arriving in the last allowed MEM cycle beats the timeout.
        nbe = 0;
        for (int i = 0; i < 19; i++) begin
            tick(1'b0, OpSw, 1'b0, 1'b1, i == 18);
            if (i == 0) chk("ill_no_retire", 32'(g_ret), 32'(exp_ret(4)));
            nbe += int'(g.bus_err);
            if (i == 18) chk("sw_ready_at_limit", {g.mem_write, g.bus_err, g.pc_write}, 3'b101);
        end
        chk("sw_ready_at_limit_buserr", nbe, 0);

        repeat (64) tick(1'b0, OpR, 1'b0, 1'b1, 1'b1);
        tick(1'b0, OpR, 1'b0, 1'b0, 1'b0);
        chk("retired_wrap", 32'(g_ret), 32'(exp_ret(5)));

        drop = 0;
        for (int n = 0; n < 4000; n++) begin
            if (m_idx == 0) drop = ($urandom % 5 == 0);
            tmp = $urandom;
            case ($urandom % 6)
                0: rop = OpR;
                1: rop = OpLw;
                2: rop = OpSw;
                3: rop = OpBeq;
                4: rop = OpIll;
                default: rop = tmp[6:0];
            endcase
            tick($urandom % 150 == 0, rop, tmp[7], $urandom % 3 != 0,
                 drop ? 1'b0 : ($urandom % 3 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
